// File: rtl/button_register.sv
// button_register: four synchronised, debounced push-buttons with W1C rising-edge pending bits and a level irq
module button_register #(
  parameter int DEBOUNCE_COUNT = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cs,
  input  logic       read,
  input  logic       write,
  input  logic       address,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic [3:0] buttons,
  output logic       irq
);
  localparam int CW = (DEBOUNCE_COUNT > 1) ? $clog2(DEBOUNCE_COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_COUNT - 1);
  logic [3:0] sync1, sync2, stable, stable_next, pending, pending_next, clr;
  logic [CW-1:0] cnt [4];
  logic [CW-1:0] cnt_next [4];
  logic irq_enable, wr_ctrl;
  logic [7:0] sel;
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_next[i] = (sync2[i] == stable[i] || cnt[i] == LAST) ? '0 : cnt[i] + 1'b1;
      stable_next[i] = (sync2[i] != stable[i] && cnt[i] == LAST) ? sync2[i] : stable[i];
    end
    wr_ctrl = cs && write && address;
    clr = wr_ctrl ? data_in[3:0] : 4'b0000;
    // a rising edge on the same cycle as a clear keeps the bit set
    pending_next = (pending & ~clr) | (stable_next & ~stable);
    sel = address ? {irq_enable, 3'b000, pending} : {4'b0000, stable};
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      stable <= '0;
      pending <= '0;
      irq_enable <= 1'b0;
      irq <= 1'b0;
      data_out <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1 <= buttons;
      sync2 <= sync1;
      stable <= stable_next;
      pending <= pending_next;
      irq_enable <= wr_ctrl ? data_in[7] : irq_enable;
      irq <= irq_enable && (pending != 4'b0000);
      data_out <= (cs && read) ? sel : data_out;
      for (int i = 0; i < 4; i++) cnt[i] <= cnt_next[i];
    end
  end
endmodule

// File: tb/tb_button_register.sv
// tb_button_register: directed test-plan checks plus random stimulus against a behavioural model
module tb_button_register;
  localparam int D = 4;
  logic clock = 0, reset = 1, cs = 0, read = 0, write = 0, address = 0, irq;
  logic [7:0] data_in = 0, data_out;
  logic [3:0] buttons = 0;
  int total = 0, bad = 0;
  logic [3:0] m_s1, m_s2, m_stable, m_pend;
  int m_run [4];
  logic m_en, m_irq;
  logic [7:0] m_dout;

  always #5 clock = ~clock;

  button_register #(.DEBOUNCE_COUNT(D)) dut (
    .clock(clock), .reset(reset), .cs(cs), .read(read), .write(write),
    .address(address), .data_in(data_in), .data_out(data_out),
    .buttons(buttons), .irq(irq)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // one clock of the reference: a button flips once it has disagreed for D straight cycles
  task automatic model();
    logic [3:0] rise;
    logic n_irq;
    rise = 0;
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_stable = 0; m_pend = 0; m_en = 0; m_irq = 0; m_dout = 0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
    end else begin
      n_irq = m_en && (m_pend != 0);
      if (cs && read) m_dout = address ? {m_en, 3'b000, m_pend} : {4'b0000, m_stable};
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] == m_stable[i]) m_run[i] = 0;
        else begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_stable[i] = m_s2[i];
            m_run[i] = 0;
            rise[i] = m_s2[i];
          end
        end
      end
      if (cs && write && address) begin
        m_pend = m_pend & ~data_in[3:0];
        m_en = data_in[7];
      end
      m_pend = m_pend | rise;
      m_s2 = m_s1;
      m_s1 = buttons;
      m_irq = n_irq;
    end
  endtask

  task automatic tick();
    model();
    @(posedge clock);
    #1;
    chk("dout", data_out, m_dout);
    chk("irq", {7'b0, irq}, {7'b0, m_irq});
  endtask

  task automatic bus(input logic r, input logic w, input logic a, input logic [7:0] d);
    cs = r | w; read = r; write = w; address = a; data_in = d;
    tick();
    cs = 0; read = 0; write = 0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    idle(2);
    reset = 0;
    bus(1, 0, 0, 0); chk("rst_state", data_out, 8'h00);
    bus(1, 0, 1, 0); chk("rst_ctrl", data_out, 8'h00); chk("rst_irq", {7'b0, irq}, 8'h00);
    buttons = 4'b0001;
    cs = 1; read = 1; address = 0;
    for (int t = 0; t <= 6; t++) begin tick(); chk("deb_edge", data_out, t == 6 ? 8'h01 : 8'h00); end
    cs = 0; read = 0;
    bus(1, 0, 0, 0); chk("latch_state", data_out, 8'h01);
    bus(1, 0, 1, 0); chk("latch_pend", data_out, 8'h01);
    buttons = 4'b0101; idle(3);
    buttons = 4'b0001; idle(4);
    bus(1, 0, 1, 0); chk("glitch_pend", data_out, 8'h01);
    bus(1, 0, 0, 0); chk("glitch_state", data_out, 8'h01);
    buttons = 4'b0101;
    cs = 1; read = 1; address = 0;
    for (int t = 0; t <= 6; t++) begin tick(); chk("glitch_hold", data_out, t == 6 ? 8'h05 : 8'h01); end
    cs = 0; read = 0;
    bus(0, 1, 1, 8'h0F);
    bus(0, 1, 1, 8'h80);
    buttons = 4'b1101;
    for (int t = 0; t <= 7; t++) begin tick(); chk("irq_edge", {7'b0, irq}, t >= 6 ? 8'h01 : 8'h00); end
    bus(0, 1, 1, 8'h88); chk("irq_hold", {7'b0, irq}, 8'h01);
    tick(); chk("irq_clear", {7'b0, irq}, 8'h00);
    bus(0, 1, 1, 8'h00);
    bus(1, 0, 1, 0); chk("en_off", data_out, 8'h00);
    buttons = 4'b1111;
    idle(5);
    bus(0, 1, 1, 8'h02);
    bus(1, 0, 1, 0); chk("collision", data_out, 8'h02);
    buttons = 4'b1110; idle(7);
    bus(1, 0, 0, 0); chk("release_state", data_out, 8'h0E);
    bus(1, 0, 1, 0); chk("release_pend", data_out, 8'h02);
    buttons = 4'b1100; idle(7);
    bus(1, 0, 0, 0); chk("release1", data_out, 8'h0C);
    buttons = 4'b1110; idle(3);
    reset = 1; tick(); reset = 0;
    cs = 1; read = 1; address = 0;
    for (int t = 0; t <= 6; t++) begin tick(); chk("rst_requal", data_out, t == 6 ? 8'h0E : 8'h00); end
    cs = 0; read = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(7) == 0) buttons[$urandom_range(3)] ^= 1'b1;
      cs = $urandom_range(1); read = $urandom_range(1); write = ($urandom_range(3) == 0);
      address = $urandom_range(1); data_in = 8'($urandom);
      reset = ($urandom_range(499) == 0);
      tick();
    end
    reset = 0; cs = 0; read = 0; write = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/button_register.md
# button_register

Memory-mapped input register that lets the CPU read four push-buttons. Each raw button line is synchronised, debounced and edge-detected. Rising edges are latched into write-1-to-clear pending bits, which can raise a level interrupt. The block sits on the same chip-select/read/write peripheral bus as the other single-function registers in the core.

## Interface

Parameters:
- DEBOUNCE_COUNT, 50000, consecutive clock cycles a synchronised input must differ from the debounced state before that state changes; legal range 1..65535.

Ports:
- clock  input  1  system clock; all logic on its rising edge
- reset  input  1  synchronous, active-high reset
- cs  input  1  chip select for this register block
- read  input  1  read strobe, qualified by cs
- write  input  1  write strobe, qualified by cs
- address  input  1  register select: 0 = STATE, 1 = PENDING/CONTROL
- data_in  input  8  write data
- data_out  output  8  registered read data
- buttons  input  4  raw, asynchronous, active-high button lines
- irq  output  1  registered level interrupt, active-high

## Operation

- **Reset** (synchronous, active-high): clears both synchroniser stages, all debounce counters, stable[3:0], pending[3:0], irq_enable, irq and data_out to 0.
- **Synchroniser:** two flops per button, sync1 <= buttons, then sync2 <= sync1.
- **Debounce,** per button i, with one counter of width clog2(DEBOUNCE_COUNT), minimum 1 bit:
  - If sync2[i] == stable[i]: counter <= 0.
  - Else if counter == DEBOUNCE_COUNT-1: stable[i] <= sync2[i] and counter <= 0.
  - Else: counter <= counter+1.
  - A glitch shorter than DEBOUNCE_COUNT cycles, as seen at sync2, never changes stable.
- **Edge latch:**
  - On the same edge that stable[i] goes 0->1, pending[i] <= 1.
  - Falling transitions do not touch pending.
- **Register map:**
  - Read address 0 (STATE): {4'b0000, stable[3:0]}.
  - Read address 1 (PENDING/CONTROL): {irq_enable, 3'b000, pending[3:0]}.
  - Write address 0: ignored; no state changes.
  - Write address 1: for each i, pending[i] cleared if data_in[i] == 1; irq_enable <= data_in[7]; data_in[6:4] ignored.
- **Simultaneous events:**
  - A set and a write-1-to-clear of the same pending bit on the same edge: set wins, so the bit ends at 1.
  - cs with both read and write asserted: both actions occur. data_out captures the pre-write register values.
- **Read data:**
  - On an edge with cs && read, data_out <= the selected register.
  - Otherwise data_out holds its last value. No read side-effects.
- **Interrupt:** irq <= irq_enable && (pending != 0), registered.
- Strobes without cs have no effect.

## Timing

- Let edge 0 be the first rising edge that samples a changed, steady buttons[i]:
  - sync2 reflects the change after edge 1.
  - stable[i] and pending[i] update at edge DEBOUNCE_COUNT+1.
  - irq asserts at edge DEBOUNCE_COUNT+2, if irq_enable is set.
- Read latency: one cycle. data_out is valid after the edge on which cs && read is sampled.
- Write effect: pending and irq_enable update on the edge that samples cs && write. irq reflects the change one edge later.
- Reset asserted mid-debounce discards any partial count. After reset deasserts, a held button re-qualifies from scratch and takes the full DEBOUNCE_COUNT+2 edges again.
- Strobes are single-cycle or level. A strobe held for N cycles performs the action N times, which is idempotent for every register.

## Test plan

All scenarios use DEBOUNCE_COUNT=4.

1. **Reset state:** assert reset for 2 cycles, then read address 0 and address 1 -> data_out 8'h00 both times; irq 0.
2. **Debounce and latch:** buttons 4'b0000 -> 4'b0001, held -> stable[0] and pending[0] set at edge 5 after the change. Then read address 0 -> 8'h01; read address 1 -> 8'h01.
3. **Glitch rejection:** button 2 pulsed high for 3 cycles -> stable stays 0, pending stays 0. The counter must be back at 0, checked by then holding the button high: stable rises exactly 5 edges after the hold starts.
4. **Interrupt and clear:** write address 1 with 8'h80; press button 3 -> irq 1 at edge 6. Write address 1 with 8'h88 -> pending 0, irq 0 one edge later. Write 8'h00 -> irq_enable 0.
5. **Set/clear collision:** write 8'h02 to address 1 on the same edge that stable[1] rises -> read address 1 returns 8'h02 (8'h82 if enabled).
6. **Release and reset mid-count:**
   - Release button 0 -> stable[0] falls, pending unchanged.
   - Hold button 1 for 3 cycles, pulse reset, keep holding -> stable[1] rises 5 edges after reset deasserts.
